mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the datapath's instruction-fetch and data-access ports onto one single-ported memory bus with a ready handshake. Sits between the datapath (consumer of `ihit`/`dhit`, `imem_load`/`dload`) and the memory model or cache. Registers every memory transaction, returns one-cycle hit pulses, and alternates grants round-robin when both ports request.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8`
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `iren`  in  1  instruction read request, held until `ihit`
- `iaddr`  in  ADDR_W  instruction address
- `iload`  out  DATA_W  fetched instruction, valid while `ihit`=1
- `ihit`  out  1  one-cycle completion pulse, instruction port
- `dren`  in  1  data read request, held until `dhit`
- `dwen`  in  1  data write request, held until `dhit`
- `daddr`  in  ADDR_W  data address
- `dstore`  in  DATA_W  write data
- `dbe`  in  DATA_W/8  write byte enables
- `dload`  out  DATA_W  read data, valid while `dhit`=1 on a read
- `dhit`  out  1  one-cycle completion pulse, data port
- `mem_ren`, `mem_wen`  out  1  memory strobes
- `mem_addr`  out  ADDR_W  memory address
- `mem_store`  out  DATA_W  memory write data
- `mem_be`  out  DATA_W/8  memory byte enables
- `mem_load`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completes current access this cycle

## Operation
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE: sample requests. Only instruction -> IACC. Only data -> DACC. Both -> grant opposite of `last_grant`. None -> stay.
- On leaving IDLE, latch address, store data, byte enables and read/write into registers; memory outputs driven only from latches.
- `dren` and `dwen` both high: treated as write.
- IACC: `mem_ren`=1, `mem_addr`={latched addr[ADDR_W-1:2], 2'b00}, `mem_be`=all ones. Stay until `mem_ready`; then capture `mem_load` into `iload`, set `last_grant`=I, go RESP.
- DACC: `mem_ren` or `mem_wen`=1, `mem_addr`=latched `daddr` unmodified, `mem_be`=latched `dbe` (all ones on read). On `mem_ready`, capture `mem_load` into `dload` for reads only, set `last_grant`=D, go RESP.
- RESP: assert `ihit` or `dhit` for the granted port, exactly one cycle; memory strobes low; no new grant; next state IDLE.
- Request dropped mid-access: access still completes and hit still pulses.
- `iload`/`dload` hold their last captured value outside the hit cycle; `dload` is unchanged by writes.
- Never both `mem_ren` and `mem_wen` high; never both hits high.

## Timing
- Reset values: state IDLE, `last_grant`=D (instruction wins first tie), all strobes, hits, `mem_addr`, `mem_store`, `mem_be`, `iload`, `dload` = 0.
- Reset is synchronous: `rst` sampled high aborts any access; strobes low and no hit from the next cycle. No pending hit survives reset.
- Zero-wait access: request seen in IDLE cycle 0, strobe in cycle 1 with `mem_ready`=1, hit in cycle 2, IDLE in cycle 3. One access per 3 cycles minimum.
- N wait states add N cycles in IACC/DACC. Strobes and address stay stable until `mem_ready`.
- Requester may drop the request in the cycle after its hit. Because IDLE follows RESP, a request that is still high in the hit cycle is not double-granted.

## Structure
- `rv32ima_pkg` gets `arb_state_t` (IDLE/IACC/DACC/RESP) and `arb_grant_t` (I/D). It reuses `word_t`.
- Single flat module, no sub-modules. A `mem_arbiter_if` interface bundles the three port groups with `dp`/`mem` modports.

## Test plan
- Instruction only, `iaddr`=0x0000_0106, zero wait -> `mem_addr`=0x0000_0104, `ihit` in cycle 2, `iload`=`mem_load`.
- Data write `daddr`=0x40, `dstore`=0xDEADBEEF, `dbe`=4'b0011, 2 wait states -> `mem_wen` high 3 cycles, `dhit` in cycle 4, `dload` unchanged.
- Both requesting continuously from reset -> grants alternate I,D,I,D. Hits never overlap and never arrive less than 3 cycles apart.
- `dren` and `dwen` both high -> write performed, `mem_ren`=0.
- `rst` raised during DACC wait state -> strobes low the next cycle, no `dhit`, state IDLE, `last_grant`=D.
- `iren` dropped mid-IACC -> access completes, `ihit` still pulses once, then idle.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima datapath and its memory-side glue.
//   word_t      : native machine word
//   arb_state_t : mem_arbiter sequencing states
//   arb_grant_t : which datapath port owns the memory bus
package rv32ima_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three mem_arbiter port groups (instruction, data, memory).
//   dp  : datapath view (drives requests, receives loads and hits)
//   mem : memory/cache view (receives strobes, drives load data and ready)
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   // instruction port
   logic              iren;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] iload;
   logic              ihit;
   // data port
   logic              dren;
   logic              dwen;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic [BE_W-1:0]   dbe;
   logic [DATA_W-1:0] dload;
   logic              dhit;
   // memory bus
   logic              mem_ren;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_store;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_load;
   logic              mem_ready;

   modport dp (
      output iren, iaddr, dren, dwen, daddr, dstore, dbe,
      input  iload, ihit, dload, dhit
   );

   modport mem (
      input  mem_ren, mem_wen, mem_addr, mem_store, mem_be,
      output mem_load, mem_ready
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, ready-handshaked memory bus between
// the instruction-fetch and data-access ports of the datapath.
//   clk, rst                          : clock, synchronous active-high reset
//   iren/iaddr -> iload/ihit          : instruction read port
//   dren/dwen/daddr/dstore/dbe
//                -> dload/dhit        : data read/write port
//   mem_ren/mem_wen/mem_addr/
//   mem_store/mem_be                  : memory request (from latched copies)
//   mem_load/mem_ready                : memory response
// Every access is latched on leaving IDLE, completes on mem_ready, and is
// followed by a single RESP cycle carrying the hit pulse. Ties are broken
// round-robin against the port that completed last.
module mem_arbiter
   import rv32ima_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iren,
   input  logic [ADDR_W-1:0]     iaddr,
   output logic [DATA_W-1:0]     iload,
   output logic                  ihit,
   input  logic                  dren,
   input  logic                  dwen,
   input  logic [ADDR_W-1:0]     daddr,
   input  logic [DATA_W-1:0]     dstore,
   input  logic [DATA_W/8-1:0]   dbe,
   output logic [DATA_W-1:0]     dload,
   output logic                  dhit,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_store,
   output logic [DATA_W/8-1:0]   mem_be,
   input  logic [DATA_W-1:0]     mem_load,
   input  logic                  mem_ready
);

   localparam int BE_W = DATA_W / 8;

   arb_state_t        state, state_nx;
   arb_grant_t        last_grant;   // port that completed most recently
   arb_grant_t        cur_grant;    // port owning the access in flight
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] store_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] iload_q;
   logic [DATA_W-1:0] dload_q;
   logic              dreq;

   assign dreq = dren | dwen;

   always_comb begin
      state_nx = state;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      ihit     = 1'b0;
      dhit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (iren && dreq)
               state_nx = (last_grant == GRANT_D) ? IACC : DACC;
            else if (iren)
               state_nx = IACC;
            else if (dreq)
               state_nx = DACC;
         end
         IACC: begin
            mem_ren = 1'b1;
            if (mem_ready) state_nx = RESP;
         end
         DACC: begin
            mem_ren = ~wr_q;
            mem_wen = wr_q;
            if (mem_ready) state_nx = RESP;
         end
         RESP: begin
            // Always back through IDLE so a request still high during its
            // hit cycle is not granted a second time.
            ihit     = (cur_grant == GRANT_I);
            dhit     = (cur_grant == GRANT_D);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_D;
         cur_grant  <= GRANT_D;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         be_q       <= '0;
         iload_q    <= '0;
         dload_q    <= '0;
      end else begin
         state <= state_nx;

         if (state == IDLE && state_nx == IACC) begin
            cur_grant <= GRANT_I;
            wr_q      <= 1'b0;
            addr_q    <= iaddr;
            be_q      <= '1;
         end
         if (state == IDLE && state_nx == DACC) begin
            // dren together with dwen is a write.
            cur_grant <= GRANT_D;
            wr_q      <= dwen;
            addr_q    <= daddr;
            store_q   <= dstore;
            be_q      <= dwen ? dbe : '1;
         end

         if (state == IACC && mem_ready) begin
            iload_q    <= mem_load;
            last_grant <= GRANT_I;
         end
         if (state == DACC && mem_ready) begin
            if (!wr_q) dload_q <= mem_load;
            last_grant <= GRANT_D;
         end
      end
   end

   // Instruction fetches are word-aligned on the bus; data addresses pass
   // through untouched.
   assign mem_addr  = (cur_grant == GRANT_I) ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
   assign mem_store = store_q;
   assign mem_be    = be_q;
   assign iload     = iload_q;
   assign dload     = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iren = 1'b0, dren = 1'b0, dwen = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
   logic [3:0]  dbe = '0;
   logic [31:0] iload, dload, mem_addr, mem_store;
   logic        ihit, dhit, mem_ren, mem_wen;
   logic [3:0]  mem_be;
   logic [31:0] mem_load = '0;
   logic        mem_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   // bus_mem is what the memory model serves; ref_mem is the bench's view of
   // what the datapath should observe, updated only when a write hits.
   logic [31:0] bus_mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] exp_dload;

   int  mem_wait  = 0;
   bit  rand_wait = 1'b0;
   int  wcnt      = 0;
   int  cur_wait  = 0;
   bit  active    = 1'b0;
   int  cyc       = 0;
   int  last_hit  = -100;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .iren(iren), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dbe(dbe),
      .dload(dload), .dhit(dhit),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_store(mem_store), .mem_be(mem_be),
      .mem_load(mem_load), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Memory model: N wait cycles then ready; garbage on mem_load otherwise.
   always @(negedge clk) begin
      if (rst === 1'b1 || !(mem_ren === 1'b1 || mem_wen === 1'b1)) begin
         active    = 1'b0;
         wcnt      = 0;
         mem_ready = 1'b0;
         mem_load  = $urandom;
      end else begin
         if (!active) begin
            active   = 1'b1;
            wcnt     = 0;
            cur_wait = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
         end
         if (wcnt >= cur_wait) begin
            mem_ready = 1'b1;
            mem_load  = bus_mem[mem_addr[9:2]];
            if (mem_wen === 1'b1)
               bus_mem[mem_addr[9:2]] = merge(bus_mem[mem_addr[9:2]], mem_store, mem_be);
         end else begin
            mem_ready = 1'b0;
            mem_load  = $urandom;
            wcnt++;
         end
      end
   end

   always @(posedge clk) cyc++;

   // Bus-wide invariants, checked whenever something is happening.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (ihit === 1'b1 || dhit === 1'b1) begin
            checks++;
            if (ihit === 1'b1 && dhit === 1'b1) begin
               errors++; $display("FAIL both_hits: ihit=%b dhit=%b required not both", ihit, dhit);
            end
            checks++;
            if (cyc - last_hit < 3) begin
               errors++; $display("FAIL hit_spacing: %0d cycles required >=3", cyc - last_hit);
            end
            last_hit = cyc;
         end
         if (mem_ren === 1'b1 || mem_wen === 1'b1) begin
            checks++;
            if (mem_ren === 1'b1 && mem_wen === 1'b1) begin
               errors++; $display("FAIL both_strobes: ren=%b wen=%b required not both", mem_ren, mem_wen);
            end
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1; iren = 0; dren = 0; dwen = 0;
      iaddr = '0; daddr = '0; dstore = '0; dbe = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Driving helpers: start in cycle 0 (just after a clock edge), hold the
   // request until the hit, drop it in the following cycle.
   task automatic i_txn(input logic [31:0] addr, output int hit_cyc, output logic [31:0] ld,
                        output int ren_n, output logic [31:0] addr_seen, output logic [3:0] be_seen);
      bit first = 1'b1;
      iaddr = addr; iren = 1'b1;
      hit_cyc = -1; ld = '0; ren_n = 0; addr_seen = '0; be_seen = '0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (mem_ren === 1'b1) begin
            ren_n++;
            if (first) begin addr_seen = mem_addr; be_seen = mem_be; first = 1'b0; end
         end
         if (ihit === 1'b1) begin hit_cyc = c; ld = iload; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      iren = 1'b0;
   endtask

   task automatic d_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int hit_cyc, output logic [31:0] ld,
                        output int ren_n, output int wen_n,
                        output logic [31:0] addr_seen, output logic [3:0] be_seen,
                        output logic [31:0] store_seen, output bit stable);
      bit first = 1'b1;
      daddr = addr; dstore = data; dbe = be; dren = rd; dwen = wr;
      hit_cyc = -1; ld = '0; ren_n = 0; wen_n = 0; stable = 1'b1;
      addr_seen = '0; be_seen = '0; store_seen = '0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (mem_ren === 1'b1) ren_n++;
         if (mem_wen === 1'b1) wen_n++;
         if (mem_ren === 1'b1 || mem_wen === 1'b1) begin
            if (first) begin
               addr_seen = mem_addr; be_seen = mem_be; store_seen = mem_store; first = 1'b0;
            end else if (mem_addr !== addr_seen || mem_be !== be_seen || mem_store !== store_seen)
               stable = 1'b0;
         end
         if (dhit === 1'b1) begin hit_cyc = c; ld = dload; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      dren = 1'b0; dwen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if ({mem_ren, mem_wen, ihit, dhit} !== 4'b0) begin
         errors++; $display("FAIL reset_strobes: ren,wen,ihit,dhit=%b required 0000", {mem_ren, mem_wen, ihit, dhit});
      end
      checks++; if (mem_addr !== 32'h0 || mem_store !== 32'h0 || mem_be !== 4'h0) begin
         errors++; $display("FAIL reset_bus: addr=%h store=%h be=%h required 0", mem_addr, mem_store, mem_be);
      end
      checks++; if (iload !== 32'h0 || dload !== 32'h0) begin
         errors++; $display("FAIL reset_loads: iload=%h dload=%h required 0", iload, dload);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_ifetch();
      int h, rn; logic [31:0] ld, as; logic [3:0] bs;
      apply_reset(); mem_wait = 0;
      i_txn(32'h0000_0106, h, ld, rn, as, bs);
      checks++; if (h !== 2) begin errors++; $display("FAIL ifetch_hit_cycle: %0d required 2", h); end
      checks++; if (as !== 32'h0000_0104) begin errors++; $display("FAIL ifetch_addr: %h required 00000104", as); end
      checks++; if (bs !== 4'hF) begin errors++; $display("FAIL ifetch_be: %h required f", bs); end
      checks++; if (rn !== 1) begin errors++; $display("FAIL ifetch_ren_cycles: %0d required 1", rn); end
      checks++; if (ld !== ref_mem[8'h41]) begin errors++; $display("FAIL ifetch_data: %h required %h", ld, ref_mem[8'h41]); end
      @(negedge clk);
      checks++; if (ihit !== 1'b0 || mem_ren !== 1'b0) begin
         errors++; $display("FAIL ifetch_after: ihit=%b ren=%b required 0 0", ihit, mem_ren);
      end
   endtask

   task automatic test_dwrite();
      int h, rn, wn; logic [31:0] ld, as, ss; logic [3:0] bs; bit st;
      apply_reset(); mem_wait = 0;
      d_txn(1, 0, 32'h40, 32'h0, 4'h0, h, ld, rn, wn, as, bs, ss, st);
      checks++; if (ld !== ref_mem[16]) begin errors++; $display("FAIL dread_data: %h required %h", ld, ref_mem[16]); end
      checks++; if (bs !== 4'hF) begin errors++; $display("FAIL dread_be: %h required f", bs); end
      exp_dload = ref_mem[16];
      mem_wait = 2;
      d_txn(0, 1, 32'h40, 32'hDEADBEEF, 4'b0011, h, ld, rn, wn, as, bs, ss, st);
      checks++; if (wn !== 3 || rn !== 0) begin errors++; $display("FAIL dwrite_strobes: wen=%0d ren=%0d required 3 0", wn, rn); end
      checks++; if (h !== 4) begin errors++; $display("FAIL dwrite_hit_cycle: %0d required 4", h); end
      checks++; if (as !== 32'h40 || bs !== 4'b0011 || ss !== 32'hDEADBEEF) begin
         errors++; $display("FAIL dwrite_bus: addr=%h be=%h store=%h required 00000040 3 deadbeef", as, bs, ss);
      end
      checks++; if (!st) begin errors++; $display("FAIL dwrite_stable: bus changed during wait required stable"); end
      checks++; if (ld !== exp_dload) begin errors++; $display("FAIL dwrite_dload: %h required %h", ld, exp_dload); end
      ref_mem[16] = merge(ref_mem[16], 32'hDEADBEEF, 4'b0011);
      mem_wait = 0;
      d_txn(1, 0, 32'h40, 32'h0, 4'h0, h, ld, rn, wn, as, bs, ss, st);
      checks++; if (ld !== ref_mem[16]) begin errors++; $display("FAIL dwrite_readback: %h required %h", ld, ref_mem[16]); end
   endtask

   task automatic test_both_rw();
      int h, rn, wn; logic [31:0] ld, as, ss, wd; logic [3:0] bs; bit st;
      apply_reset(); mem_wait = 0;
      wd = $urandom;
      d_txn(1, 1, 32'h47, wd, 4'b1100, h, ld, rn, wn, as, bs, ss, st);
      checks++; if (rn !== 0 || wn !== 1) begin errors++; $display("FAIL rw_as_write: ren=%0d wen=%0d required 0 1", rn, wn); end
      checks++; if (as !== 32'h47) begin errors++; $display("FAIL rw_addr_unmodified: %h required 00000047", as); end
      checks++; if (h !== 2) begin errors++; $display("FAIL rw_hit_cycle: %0d required 2", h); end
      ref_mem[17] = merge(ref_mem[17], wd, 4'b1100);
      d_txn(1, 0, 32'h44, 32'h0, 4'h0, h, ld, rn, wn, as, bs, ss, st);
      checks++; if (ld !== ref_mem[17]) begin errors++; $display("FAIL rw_readback: %h required %h", ld, ref_mem[17]); end
   endtask

   task automatic test_alternate();
      int seq[$];
      apply_reset(); mem_wait = 0;
      iaddr = 32'h20; daddr = 32'h30; iren = 1'b1; dren = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ihit === 1'b1) begin
            seq.push_back(0);
            checks++; if (iload !== ref_mem[8]) begin errors++; $display("FAIL alt_iload: %h required %h", iload, ref_mem[8]); end
         end
         if (dhit === 1'b1) begin
            seq.push_back(1);
            checks++; if (dload !== ref_mem[12]) begin errors++; $display("FAIL alt_dload: %h required %h", dload, ref_mem[12]); end
         end
         @(posedge clk); #1;
      end
      iren = 1'b0; dren = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (seq.size() < 8) begin errors++; $display("FAIL alt_count: %0d hits required >=8", seq.size()); end
      for (int k = 0; k < seq.size(); k++) begin
         checks++; if (seq[k] != (k % 2)) begin
            errors++; $display("FAIL alt_order: hit %0d port %0d required %0d", k, seq[k], k % 2);
         end
      end
   endtask

   task automatic test_reset_mid();
      int h, rn, wn, bad; logic [31:0] ld, as; logic [3:0] bs; int first;
      apply_reset(); mem_wait = 0;
      i_txn(32'h10, h, ld, rn, as, bs);      // leaves the I port as last winner
      mem_wait = 5;
      daddr = 32'h50; dstore = 32'h12345678; dbe = 4'hF; dwen = 1'b1;
      wn = 0;
      for (int c = 0; c < 20 && wn < 2; c++) begin
         @(negedge clk);
         if (mem_wen === 1'b1) wn++;
         @(posedge clk); #1;
      end
      rst = 1'b1; dwen = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if ({mem_ren, mem_wen, dhit} !== 3'b0) begin
         errors++; $display("FAIL rst_abort: ren,wen,dhit=%b required 000", {mem_ren, mem_wen, dhit});
      end
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_quiet: %0d busy cycles required 0", bad); end
      checks++; if (bus_mem[20] !== ref_mem[20]) begin
         errors++; $display("FAIL rst_no_write: mem=%h required %h", bus_mem[20], ref_mem[20]);
      end
      // Tie right after reset goes to the instruction port.
      @(posedge clk); #1;
      mem_wait = 0; iaddr = 32'h8; daddr = 32'hC; iren = 1'b1; dren = 1'b1;
      first = -1;
      for (int c = 0; c < 20 && first < 0; c++) begin
         @(negedge clk);
         if (ihit === 1'b1) first = 0;
         else if (dhit === 1'b1) first = 1;
         @(posedge clk); #1;
      end
      iren = 1'b0; dren = 1'b0;
      checks++; if (first != 0) begin errors++; $display("FAIL rst_last_grant: first port %0d required 0", first); end
      repeat (4) @(posedge clk); #1;
   endtask

   task automatic test_idrop();
      int hits = 0, rn = 0; logic [31:0] ld = '0;
      apply_reset(); mem_wait = 3;
      iaddr = 32'h84; iren = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (mem_ren === 1'b1) rn++;
         if (ihit === 1'b1) begin hits++; ld = iload; end
         @(posedge clk); #1;
         if (c == 1) iren = 1'b0;
      end
      checks++; if (hits != 1) begin errors++; $display("FAIL idrop_hits: %0d required 1", hits); end
      checks++; if (rn != 4) begin errors++; $display("FAIL idrop_ren_cycles: %0d required 4", rn); end
      checks++; if (ld !== ref_mem[33]) begin errors++; $display("FAIL idrop_data: %h required %h", ld, ref_mem[33]); end
   endtask

   task automatic test_random();
      apply_reset(); rand_wait = 1'b1;
      exp_dload = '0;
      fork
         begin
            int h, rn; logic [31:0] ld, as, a; logic [3:0] bs;
            for (int n = 0; n < 25; n++) begin
               a = $urandom_range(0, 1023);
               i_txn(a, h, ld, rn, as, bs);
               checks++; if (h < 0) begin errors++; $display("FAIL rand_i_timeout: txn %0d no ihit", n); end
               checks++; if (ld !== ref_mem[a[9:2]]) begin
                  errors++; $display("FAIL rand_iload: addr %h got %h required %h", a, ld, ref_mem[a[9:2]]);
               end
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
         begin
            int h, rn, wn, mode; logic [31:0] ld, as, ss, a, wd; logic [3:0] bs, be; bit st;
            for (int n = 0; n < 25; n++) begin
               mode = $urandom_range(0, 2);
               a  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
               wd = $urandom;
               be = 4'($urandom_range(1, 15));
               d_txn(mode != 1, mode != 0, a, wd, be, h, ld, rn, wn, as, bs, ss, st);
               checks++; if (h < 0) begin errors++; $display("FAIL rand_d_timeout: txn %0d no dhit", n); end
               if (mode == 0) begin
                  checks++; if (ld !== ref_mem[a[9:2]]) begin
                     errors++; $display("FAIL rand_dload: addr %h got %h required %h", a, ld, ref_mem[a[9:2]]);
                  end
                  exp_dload = ref_mem[a[9:2]];
               end else begin
                  checks++; if (ld !== exp_dload) begin
                     errors++; $display("FAIL rand_dload_hold: got %h required %h", ld, exp_dload);
                  end
                  ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wd, be);
               end
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
      join
      rand_wait = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         bus_mem[i] = $urandom;
         ref_mem[i] = bus_mem[i];
      end
      test_reset();
      test_ifetch();
      test_dwrite();
      test_both_rw();
      test_alternate();
      test_reset_mid();
      test_idrop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
